dmi_req_sequencer: RTL and testbench
====================================

// Module: dmi_req_sequencer
// PURPOSE
// - Synthesisable DMI master. Buffers host debug commands, issues them one at a time on the DMI req/resp channel and returns one response per command.
// - Re-issues requests that return BUSY, bounded by MAX_RETRY, and times out requests with no response.
// - Executes a local EXIT command that drives the exit code without a DMI transaction.
// - Sits between a host-side command source (DPI shim or JTAG DTM front end) and the debug module's DMI port.
// PARAMETERS
// - ADDR_W     7     DMI address width
// - DATA_W     32    DMI data width
// - CMD_DEPTH  4     command FIFO depth; power of 2, >=2
// - MAX_RETRY  15    BUSY re-issues before giving up; 0 = no retry
// - TIMEOUT    1024  cycles from req handshake to resp before abort; >=2
// PORTS
// - clk                  in   1       clock
// - reset                in   1       async active-high reset
// - cmd_valid            in   1       host command valid
// - cmd_ready            out  1       FIFO not full
// - cmd_addr             in   ADDR_W  command address
// - cmd_op               in   2       0 NOP, 1 READ, 2 WRITE, 3 EXIT (local)
// - cmd_data             in   DATA_W  write data / exit code
// - rsp_valid            out  1       response valid
// - rsp_ready            in   1       host accepts response
// - rsp_resp             out  2       0 OK, 2 FAILED, 3 BUSY (retries exhausted)
// - rsp_data             out  DATA_W  read data
// - debug_req_valid      out  1       DMI request valid
// - debug_req_ready      in   1       DMI request ready
// - debug_req_bits_addr  out  ADDR_W  DMI address
// - debug_req_bits_op    out  2       DMI op
// - debug_req_bits_data  out  DATA_W  DMI write data
// - debug_resp_valid     in   1       DMI response valid
// - debug_resp_ready     out  1       DMI response ready
// - debug_resp_bits_resp in   2       DMI response code
// - debug_resp_bits_data in   DATA_W  DMI response data
// - exit                 out  32      0 while running; {code[30:0],1'b1} after EXIT
// BEHAVIOUR
// - One clock, clk. Reset is asynchronous and active-high (reset); it clears the FIFO, returns the FSM to IDLE and clears the retry and timeout counters.
// - Reset values: all outputs 0 except cmd_ready. cmd_ready is 1 on the first cycle after reset deasserts.
// - Assertion mid-transaction drops all in-flight and buffered commands; no response is produced for them.
// - Command FIFO:
//   - Pushes on cmd_valid & cmd_ready.
//   - Simultaneous push and pop when full is legal; cmd_ready stays 0 when full.
//   - Pointers wrap mod CMD_DEPTH.
// - FSM states and transitions:
//   - IDLE: on FIFO non-empty, pop the head into the cmd register. EXIT goes to EXIT; any other op goes to REQ.
//   - REQ: drive debug_req_valid=1 with registered addr/op/data, held stable until debug_req_ready. On handshake, clear the timer and go to WAIT.
//   - WAIT: debug_resp_ready=1. On debug_resp_valid:
//     - resp==3 and retry<MAX_RETRY: retry++, go to REQ. The same request is re-issued one cycle later.
//     - Otherwise: latch resp/data, go to RESP.
//     - The timer counts every WAIT cycle. At TIMEOUT, latch resp=2, data=0, go to RESP.
//     - A response arriving in the same cycle as the timeout wins.
//   - RESP: rsp_valid=1 until rsp_ready, outputs stable. On handshake, clear retry, go to IDLE.
//   - EXIT: exit <= {cmd_data[30:0],1'b1} (sticky until reset); return OK through RESP.
// - NOP is issued on DMI like any other op and returns its DMI response.
// - Minimum latency: 1 cycle FIFO to IDLE pop, then REQ, then WAIT. rsp_valid asserts the cycle after the DMI response.
// - debug_resp_bits_resp==1 (reserved) is treated as FAILED (2).
// - Only one DMI transaction is outstanding. debug_resp_ready=0 outside WAIT.
// STRUCTURE
// - Package dmi_pkg holds:
//   - op localparams: DMI_OP_NOP/READ/WRITE/EXIT;
//   - resp localparams: DMI_RESP_OK/FAILED/BUSY;
//   - the FSM state enum;
//   - the cmd struct {addr, op, data}.
// - One sub-module: dmi_cmd_fifo (parametric depth/width, async reset, full/empty flags). FSM, retry counter and timer stay in the top.
// TESTING
// - WRITE addr 0x10 data 0xDEADBEEF, DMI resp OK -> one req with the same fields, rsp_resp=0, exit=0.
// - READ addr 0x04, DMI returns BUSY twice then OK data 0x1234 -> three identical reqs, one rsp with resp=0 data=0x1234.
// - MAX_RETRY=2, DMI always BUSY -> exactly 3 reqs, rsp_resp=3.
// - TIMEOUT=8, debug_resp_valid held 0 -> rsp_resp=2 data=0 exactly 8 cycles after the req handshake. A response on cycle 8 is taken instead.
// - Push 5 cmds with CMD_DEPTH=4 and debug_req_ready=0 -> cmd_ready=0 after the 4th buffered. Responses return in order once ready rises.
// - EXIT code 5 -> exit=0x0000000B, no DMI req. Reset mid-WAIT -> all outputs 0 and the FIFO empties.

Source files
------------

// File: rtl/dmi_pkg.sv
// Shared DMI definitions: op and response codes, sequencer FSM states,
// the buffered command payload and the DMI-to-host response mapping.
package dmi_pkg;

  localparam int unsigned DMI_ADDR_W = 7;
  localparam int unsigned DMI_DATA_W = 32;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_OP_EXIT  = 2'd3;

  localparam logic [1:0] DMI_RESP_OK     = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP,
    ST_EXIT
  } dmi_state_e;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [1:0]            op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_cmd_t;

  // Final DMI response code to host code; the reserved code 1 reads as FAILED.
  function automatic logic [1:0] dmi_map_resp(input logic [1:0] resp);
    logic [1:0] mapped;
    mapped = DMI_RESP_FAILED;
    if (resp == DMI_RESP_OK)   mapped = DMI_RESP_OK;
    if (resp == DMI_RESP_BUSY) mapped = DMI_RESP_BUSY;
    return mapped;
  endfunction

endpackage

// File: rtl/dmi_cmd_fifo.sv
// Command FIFO for the DMI sequencer.
// Ports:
//   clk, reset        clock, async active-high reset
//   push, push_data   write request (only taken while ready is high)
//   pop               remove head (ignored while empty)
//   head              current head entry
//   ready             registered "not full", low during reset
//   empty             registered empty flag
module dmi_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             ready,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ready;
  assign do_pop  = pop & ~empty;
  assign count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      ready <= (count_d != CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/dmi_req_sequencer.sv
// DMI master: buffers host commands, issues them one at a time on DMI,
// re-issues BUSY requests up to MAX_RETRY times, aborts after TIMEOUT
// cycles without a response and executes EXIT locally.
// Ports:
//   clk, reset                      clock, async active-high reset
//   cmd_valid/ready/addr/op/data    host command stream (op 3 = EXIT)
//   rsp_valid/ready/resp/data       one host response per command
//   debug_req_*                     DMI request channel
//   debug_resp_*                    DMI response channel
//   exit                            {code[30:0],1} once EXIT has executed
module dmi_req_sequencer
  import dmi_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMI_ADDR_W,
  parameter int unsigned DATA_W    = DMI_DATA_W,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned MAX_RETRY = 15,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_resp,
  output logic [DATA_W-1:0] rsp_data,
  output logic              debug_req_valid,
  input  logic              debug_req_ready,
  output logic [ADDR_W-1:0] debug_req_bits_addr,
  output logic [1:0]        debug_req_bits_op,
  output logic [DATA_W-1:0] debug_req_bits_data,
  input  logic              debug_resp_valid,
  output logic              debug_resp_ready,
  input  logic [1:0]        debug_resp_bits_resp,
  input  logic [DATA_W-1:0] debug_resp_bits_data,
  output logic [31:0]       exit
);

  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  dmi_state_e       state_q, state_d;
  dmi_cmd_t         cmd_q, cmd_d;
  dmi_cmd_t         cmd_in;
  dmi_cmd_t         fifo_head;
  logic             fifo_empty;
  logic             pop;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       rsp_resp_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic [31:0]      exit_d;

  assign cmd_in.addr = DMI_ADDR_W'(cmd_addr);
  assign cmd_in.op   = cmd_op;
  assign cmd_in.data = DMI_DATA_W'(cmd_data);

  // Request fields come straight from the command register, so they are
  // stable for the whole REQ phase and across BUSY re-issues.
  assign debug_req_bits_addr = ADDR_W'(cmd_q.addr);
  assign debug_req_bits_op   = cmd_q.op;
  assign debug_req_bits_data = DATA_W'(cmd_q.data);

  dmi_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH ($bits(dmi_cmd_t))
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (fifo_head),
    .ready     (cmd_ready),
    .empty     (fifo_empty)
  );

  // Next-state, counters and response capture.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    cmd_d      = cmd_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    rsp_resp_d = rsp_resp;
    rsp_data_d = rsp_data;
    exit_d     = exit;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = fifo_head;
          state_d = (fifo_head.op == DMI_OP_EXIT) ? ST_EXIT : ST_REQ;
        end
      end
      ST_REQ: begin
        if (debug_req_ready) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A response seen on the timeout cycle takes precedence.
        if (debug_resp_valid) begin
          if ((debug_resp_bits_resp == DMI_RESP_BUSY) && (retry_q < RTY_W'(MAX_RETRY))) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_REQ;
          end else begin
            rsp_resp_d = dmi_map_resp(debug_resp_bits_resp);
            rsp_data_d = debug_resp_bits_data;
            state_d    = ST_RESP;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rsp_resp_d = DMI_RESP_FAILED;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          retry_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_EXIT: begin
        exit_d     = {cmd_q.data[30:0], 1'b1};
        rsp_resp_d = DMI_RESP_OK;
        rsp_data_d = '0;
        state_d    = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and handshake outputs, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cmd_q            <= '0;
      retry_q          <= '0;
      timer_q          <= '0;
      rsp_resp         <= '0;
      rsp_data         <= '0;
      exit             <= '0;
      debug_req_valid  <= 1'b0;
      debug_resp_ready <= 1'b0;
      rsp_valid        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cmd_q            <= cmd_d;
      retry_q          <= retry_d;
      timer_q          <= timer_d;
      rsp_resp         <= rsp_resp_d;
      rsp_data         <= rsp_data_d;
      exit             <= exit_d;
      debug_req_valid  <= (state_d == ST_REQ);
      debug_resp_ready <= (state_d == ST_WAIT);
      rsp_valid        <= (state_d == ST_RESP);
    end
  end

endmodule

// File: tb/tb_dmi_req_sequencer.sv
// Scoreboard bench for dmi_req_sequencer (MAX_RETRY=2, TIMEOUT=8, depth 4).
// A responder plays back planned DMI responses; expected requests and host
// responses are queued when each command is driven.
module tb_dmi_req_sequencer;

  localparam int TB_TIMEOUT = 8;
  localparam int NEVER      = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [6:0]  cmd_addr;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic        debug_req_valid, debug_req_ready;
  logic [6:0]  debug_req_bits_addr;
  logic [1:0]  debug_req_bits_op;
  logic [31:0] debug_req_bits_data;
  logic        debug_resp_valid, debug_resp_ready;
  logic [1:0]  debug_resp_bits_resp;
  logic [31:0] debug_resp_bits_data;
  logic [31:0] exit;

  typedef struct {int lat; logic [1:0] resp; logic [31:0] data;} plan_t;
  typedef struct {logic [1:0] resp; logic [31:0] data; logic [31:0] ex; int lat;} rsp_t;

  logic [40:0] exp_req_q[$];
  plan_t       plan_q[$];
  rsp_t        exp_rsp_q[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  logic        req_en, rsp_en;
  logic [31:0] exit_model;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmi_req_sequencer #(
    .ADDR_W(7), .DATA_W(32), .CMD_DEPTH(4), .MAX_RETRY(2), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .debug_req_valid(debug_req_valid), .debug_req_ready(debug_req_ready),
    .debug_req_bits_addr(debug_req_bits_addr), .debug_req_bits_op(debug_req_bits_op),
    .debug_req_bits_data(debug_req_bits_data),
    .debug_resp_valid(debug_resp_valid), .debug_resp_ready(debug_resp_ready),
    .debug_resp_bits_resp(debug_resp_bits_resp), .debug_resp_bits_data(debug_resp_bits_data),
    .exit(exit)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command (called at a negedge), returns one negedge after acceptance.
  task automatic push_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Queue expectations for one command, then drive it. n_busy BUSY replies
  // precede the final reply (dresp/ddata) which arrives in WAIT cycle lat.
  task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                      input int n_busy, input int lat, input logic [1:0] dresp,
                      input logic [31:0] ddata, input logic [1:0] eresp, input logic [31:0] edata);
    plan_t p;
    rsp_t  r;
    if (op == 2'd3) begin
      exit_model = {data[30:0], 1'b1};
    end else begin
      for (int i = 0; i < n_busy; i++) begin
        exp_req_q.push_back({addr, op, data});
        p.lat = 1; p.resp = 2'd3; p.data = 32'hB0B0_0000 + 32'(i);
        plan_q.push_back(p);
      end
      exp_req_q.push_back({addr, op, data});
      p.lat = lat; p.resp = dresp; p.data = ddata;
      plan_q.push_back(p);
    end
    r.resp = eresp;
    r.data = edata;
    r.ex   = exit_model;
    r.lat  = (op == 2'd3) ? -1 : ((lat > TB_TIMEOUT) ? TB_TIMEOUT : lat);
    exp_rsp_q.push_back(r);
    push_cmd(op, addr, data);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_rsp_q.size() + exp_req_q.size()) != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_rsp_q.size() + exp_req_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, {59'd0, cmd_ready, rsp_valid, debug_req_valid, debug_resp_ready, rsp_resp[1]}
          | {63'd0, rsp_resp[0]}, 64'd0);
    check({tag, "_data"}, {rsp_data, exit}, 64'd0);
    check({tag, "_req"}, {23'd0, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data}, 64'd0);
  endtask

  // DMI responder and scoreboard monitor, all on the falling edge.
  initial begin : monitor
    plan_t cur;
    rsp_t  r;
    logic  active = 1'b0;
    logic  rsp_prev = 1'b0;
    int    wait_cnt = 0;
    cur.lat = NEVER; cur.resp = 2'd0; cur.data = 32'd0;
    debug_req_ready = 1'b0; debug_resp_valid = 1'b0;
    debug_resp_bits_resp = 2'd0; debug_resp_bits_data = 32'd0; rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      debug_resp_valid     = 1'b0;
      debug_resp_bits_resp = 2'd0;
      debug_resp_bits_data = 32'd0;
      debug_req_ready      = req_en;
      rsp_ready            = rsp_en;
      if (reset) begin
        active   = 1'b0;
        rsp_prev = 1'b0;
        continue;
      end
      if (rsp_valid && !rsp_prev && exp_rsp_q.size() > 0 && exp_rsp_q[0].lat >= 0)
        check("rsp_latency", 64'(cyc - hs_cyc), 64'(exp_rsp_q[0].lat));
      rsp_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          r = exp_rsp_q.pop_front();
          check("rsp_resp", 64'(rsp_resp), 64'(r.resp));
          check("rsp_data", 64'(rsp_data), 64'(r.data));
          check("rsp_exit", 64'(exit), 64'(r.ex));
        end
      end
      if (debug_resp_ready && active) begin
        wait_cnt++;
        if (wait_cnt == cur.lat) begin
          debug_resp_valid     = 1'b1;
          debug_resp_bits_resp = cur.resp;
          debug_resp_bits_data = cur.data;
          active = 1'b0;
        end
      end
      if (debug_req_valid && debug_req_ready) begin
        if (exp_req_q.size() == 0)
          check("req_unexpected", 64'd1, 64'd0);
        else
          check("req_fields", {23'd0, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data},
                {23'd0, exp_req_q.pop_front()});
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else cur.lat = NEVER;
        active   = 1'b1;
        wait_cnt = 0;
        hs_cyc   = cyc + 1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    cmd_valid = 1'b0; cmd_addr = 7'd0; cmd_op = 2'd0; cmd_data = 32'd0;
    req_en = 1'b1; rsp_en = 1'b1; exit_model = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    // WRITE, DMI OK
    send(2'd2, 7'h10, 32'hDEADBEEF, 0, 1, 2'd0, 32'd0, 2'd0, 32'd0);
    drain("drain_write");
    // READ, BUSY twice then OK 0x1234
    send(2'd1, 7'h04, 32'd0, 2, 2, 2'd0, 32'h1234, 2'd0, 32'h1234);
    drain("drain_busy_ok");
    // Always BUSY: 3 requests then BUSY reported
    send(2'd1, 7'h22, 32'd0, 2, 1, 2'd3, 32'h5555, 2'd3, 32'h5555);
    drain("drain_busy_exhausted");
    // NOP with FAILED, then reserved code 1 reported as FAILED
    send(2'd0, 7'h11, 32'h0, 0, 2, 2'd2, 32'h77, 2'd2, 32'h77);
    send(2'd1, 7'h12, 32'h0, 0, 3, 2'd1, 32'h99, 2'd2, 32'h99);
    drain("drain_failed");
    // Timeout, then a response on the final timeout cycle
    send(2'd1, 7'h33, 32'h0, 0, NEVER, 2'd0, 32'hFFFF, 2'd2, 32'd0);
    drain("drain_timeout");
    send(2'd1, 7'h34, 32'h0, 0, TB_TIMEOUT, 2'd0, 32'hABCD, 2'd0, 32'hABCD);
    drain("drain_timeout_race");
    // EXIT code 5: no DMI request
    send(2'd3, 7'h00, 32'd5, 0, 0, 2'd0, 32'd0, 2'd0, 32'd0);
    drain("drain_exit");
    check("exit_value", 64'(exit), 64'h0000_000B);

    // Host back-pressure holds the response
    rsp_en = 1'b0;
    send(2'd1, 7'h30, 32'h0, 0, 1, 2'd0, 32'h600D, 2'd0, 32'h600D);
    repeat (15) @(negedge clk);
    check("hold_rsp", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'h600D});
    rsp_en = 1'b1;
    drain("drain_hold");

    // FIFO fill with DMI stalled
    req_en = 1'b0;
    for (int i = 0; i < 5; i++)
      send(2'd1, 7'(8'h40 + i), 32'h0, 0, i + 1, 2'd0, 32'h100 + 32'(i), 2'd0, 32'h100 + 32'(i));
    check("fifo_full_ready", 64'(cmd_ready), 64'd0);
    check("fifo_stalled_req", 64'(debug_req_valid), 64'd1);
    req_en = 1'b1;
    drain("drain_fifo");

    // Reset mid-WAIT with one command buffered behind
    send(2'd1, 7'h50, 32'h0, 0, NEVER, 2'd0, 32'h0, 2'd2, 32'd0);
    send(2'd2, 7'h51, 32'h1, 0, 1, 2'd0, 32'h0, 2'd0, 32'd0);
    n = 0;
    while (!debug_resp_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait", 64'(debug_resp_ready), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    exp_req_q.delete();
    plan_q.delete();
    exp_rsp_q.delete();
    exit_model = 32'd0;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", 64'(cmd_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("fifo_flushed", {62'd0, debug_req_valid, rsp_valid}, 64'd0);

    // Normal operation after reset
    send(2'd2, 7'h7F, 32'h1, 0, 3, 2'd0, 32'h0, 2'd0, 32'h0);
    drain("drain_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
